// File: rtl/mod3_pkg.sv
// ============================================================================
// Module      : mod3_pkg
// Description : Shared one-hot phase constants and monitor state type for the
//               mod-3 phase counter and its consumers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod3_pkg;

  localparam logic [2:0] PH_Q0       = 3'b001;
  localparam logic [2:0] PH_Q1       = 3'b010;
  localparam logic [2:0] PH_Q2       = 3'b100;
  localparam logic [1:0] IDX_INVALID = 2'd3;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } mon_state_t;

endpackage

`default_nettype wire

// File: rtl/mod3_phase_decode.sv
// ============================================================================
// Module      : mod3_phase_decode
// Description : Combinational one-hot phase to binary index decoder with a
//               valid flag; any non one-hot code maps to IDX_INVALID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod3_phase_decode
  import mod3_pkg::*;
(
  input  logic [2:0] phase,
  output logic [1:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = IDX_INVALID;
    valid = 1'b0;
    case (phase)
      PH_Q0: begin idx = 2'd0; valid = 1'b1; end
      PH_Q1: begin idx = 2'd1; valid = 1'b1; end
      PH_Q2: begin idx = 2'd2; valid = 1'b1; end
      default: begin
        idx   = IDX_INVALID;
        valid = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mod3_phase_monitor.sv
// ============================================================================
// Module      : mod3_phase_monitor
// Description : Checks the Q0->Q1->Q2 one-hot phase order, reporting lock,
//               mismatch pulses, a sticky error flag and completed rounds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod3_phase_monitor
  import mod3_pkg::*;
#(
  parameter int ROUND_W     = 8,
  parameter int LOCK_ROUNDS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               begin_op,
  input  logic [2:0]         phase_in,
  input  logic               err_clear,
  output logic [1:0]         phase_idx,
  output logic               locked,
  output logic               phase_err,
  output logic               err_sticky,
  output logic               round_done,
  output logic [ROUND_W-1:0] round_cnt
);

  localparam int c_LOCK_COUNT = 3 * LOCK_ROUNDS;
  localparam int c_GOOD_W     = $clog2(c_LOCK_COUNT + 1);

  logic [1:0]          w_idx;
  logic                w_valid;
  logic                w_has_exp;
  logic [1:0]          w_exp_idx;
  logic                w_match;
  logic                w_round;
  logic                w_set_sticky;
  mon_state_t          w_state_next;
  logic [c_GOOD_W-1:0] w_good_next;

  logic [1:0]          r_prev_idx;
  logic                r_prev_begin;
  logic                r_prev_q1_ok;
  mon_state_t          r_state;
  logic [c_GOOD_W-1:0] r_good_cnt;

  mod3_phase_decode u_decode (
    .phase (phase_in),
    .idx   (w_idx),
    .valid (w_valid)
  );

  // An invalid predecessor carries no expectation: the next valid sample re-anchors.
  always_comb begin
    w_has_exp = 1'b1;
    w_exp_idx = 2'd0;
    if (r_prev_begin) begin
      w_exp_idx = 2'd0;
    end else if (r_prev_idx == IDX_INVALID) begin
      w_has_exp = 1'b0;
    end else if (r_prev_idx == 2'd2) begin
      w_exp_idx = 2'd0;
    end else begin
      w_exp_idx = r_prev_idx + 2'd1;
    end
  end

  assign w_match = w_valid && (!w_has_exp || (w_idx == w_exp_idx));
  assign w_round = w_match && (w_idx == 2'd2) && r_prev_q1_ok;

  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good_cnt;
    w_set_sticky = 1'b0;
    case (r_state)
      HUNT: begin
        if (!w_match) begin
          w_good_next = '0;
        end else if (r_good_cnt == c_GOOD_W'(c_LOCK_COUNT - 1)) begin
          w_state_next = LOCKED;
          w_good_next  = '0;
        end else begin
          w_good_next = r_good_cnt + c_GOOD_W'(1);
        end
      end
      LOCKED: begin
        if (!w_match) begin
          w_state_next = HUNT;
          w_good_next  = '0;
          w_set_sticky = 1'b1;
        end
      end
      default: begin
        w_state_next = HUNT;
        w_good_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_idx   <= 2'd2;
      r_prev_begin <= 1'b1;
      r_prev_q1_ok <= 1'b0;
      r_state      <= HUNT;
      r_good_cnt   <= '0;
      phase_err    <= 1'b0;
      err_sticky   <= 1'b0;
      round_done   <= 1'b0;
      round_cnt    <= '0;
    end else begin
      r_prev_idx   <= w_idx;
      r_prev_begin <= begin_op;
      r_prev_q1_ok <= w_match && (w_idx == 2'd1);
      r_state      <= w_state_next;
      r_good_cnt   <= w_good_next;
      phase_err    <= !w_match;
      round_done   <= w_round;
      // Setting wins over a simultaneous clear.
      if (w_set_sticky) begin
        err_sticky <= 1'b1;
      end else if (err_clear) begin
        err_sticky <= 1'b0;
      end
      if (begin_op) begin
        round_cnt <= '0;
      end else if (w_round) begin
        round_cnt <= round_cnt + ROUND_W'(1);
      end
    end
  end

  assign phase_idx = r_prev_idx;
  assign locked    = (r_state == LOCKED);

endmodule

`default_nettype wire
